// File: rtl/prev_layer_gradient_streamer.sv
`default_nettype none
// ============================================================================
// Module      : prev_layer_gradient_streamer
// Description : Consumer end of the backprop gradient path into FC0. On the
//               rising edge of pl_grad_valid the full per-neuron gradient
//               vector is snapshotted in one cycle, which leaves the FC1
//               gradient adder free to be cleared. The snapshot is then
//               streamed out LANES neurons per beat over a valid/ready
//               handshake to the FC0 backprop engine.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   N_NEURONS : neurons per vector (multiple of LANES)
//   PREC      : signed fixed-point gradient width in bits
//   LANES     : gradients per beat (power of two)
// Ports
//   clk           : clock, all logic on the rising edge
//   rst           : asynchronous active-high reset
//   forward       : forward pass active; aborts an in-flight stream
//   pl_gradients  : accumulated gradient vector, neuron n at slice n
//   pl_grad_valid : level, vector complete while high (rising edge = start)
//   act_i         : FC0 activations, only used when RELU_MASK_EN is defined
//   grad_o        : lane k carries the gradient of neuron base_id_o+k
//   base_id_o     : neuron index of lane 0
//   valid_o       : beat valid
//   ready_i       : downstream accepts the beat when valid_o & ready_i
//   last_o        : high with the final beat
//   done_o        : one-cycle pulse after the final beat is accepted
//   overrun_o     : sticky, a new vector arrived while busy (cleared by rst)
// Build option
//   RELU_MASK_EN  : when defined, neuron n is stored as 0 at snapshot time if
//                   its activation is <= 0 (ReLU derivative). When undefined
//                   act_i is ignored and gradients pass through unmodified.
// ============================================================================
module prev_layer_gradient_streamer #(
    parameter int N_NEURONS = 128,
    parameter int PREC      = 16,
    parameter int LANES     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          forward,
    input  logic [N_NEURONS*PREC-1:0]     pl_gradients,
    input  logic                          pl_grad_valid,
    input  logic [N_NEURONS*PREC-1:0]     act_i,
    output logic [LANES*PREC-1:0]         grad_o,
    output logic [$clog2(N_NEURONS)-1:0]  base_id_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic                          last_o,
    output logic                          done_o,
    output logic                          overrun_o
);

    localparam int C_BW      = $clog2(N_NEURONS);
    localparam int C_BEAT_W  = LANES * PREC;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                        state_q;
    logic [N_NEURONS*PREC-1:0]     snap_q;
    logic                          pgv_q;
    logic [N_NEURONS*PREC-1:0]     cap_d;
    logic                          w_start;
    logic                          w_accept;
    logic [C_BW-1:0]               w_next_base;
    logic                          w_next_last;

    // A new vector is signalled by the rising edge of the level valid.
    assign w_start  = pl_grad_valid & ~pgv_q;
    assign w_accept = valid_o & ready_i;

    // Base of the beat following the current one. On the final beat this
    // value wraps but is never used, because the stream ends first.
    assign w_next_base = base_id_o + C_BW'(LANES);
    assign w_next_last = (w_next_base == C_BW'(N_NEURONS - LANES));

    // Value written into the snapshot buffer at capture time.
`ifdef RELU_MASK_EN
    always_comb begin
        cap_d = pl_gradients;
        for (int n = 0; n < N_NEURONS; n++) begin
            // ReLU derivative: a non-positive activation blocks the gradient.
            if ($signed(act_i[n*PREC +: PREC]) <= 0) begin
                cap_d[n*PREC +: PREC] = '0;
            end
        end
    end
`else
    always_comb begin
        cap_d = pl_gradients;
    end

    // Activations are only consumed by the masking build; the port stays.
    logic w_unused_act;
    assign w_unused_act = ^act_i;
`endif

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            snap_q    <= '0;
            pgv_q     <= 1'b0;
            grad_o    <= '0;
            base_id_o <= '0;
            valid_o   <= 1'b0;
            last_o    <= 1'b0;
            done_o    <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            pgv_q <= pl_grad_valid;

            // A vector arriving while a previous one is still owned by this
            // block is dropped; the snapshot is left untouched.
            if (w_start && (state_q != S_IDLE)) begin
                overrun_o <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    done_o <= 1'b0;
                    if (w_start && !forward) begin
                        snap_q    <= cap_d;
                        state_q   <= S_STREAM;
                        valid_o   <= 1'b1;
                        base_id_o <= '0;
                        // First beat comes from the value being captured, which
                        // is identical to what lands in the snapshot this edge.
                        grad_o    <= cap_d[0 +: C_BEAT_W];
                        last_o    <= (N_NEURONS == LANES);
                    end
                end

                S_STREAM: begin
                    if (forward) begin
                        // Abort wins over a simultaneous accept.
                        state_q   <= S_IDLE;
                        valid_o   <= 1'b0;
                        last_o    <= 1'b0;
                        done_o    <= 1'b0;
                        base_id_o <= '0;
                    end else if (w_accept) begin
                        if (last_o) begin
                            state_q <= S_DONE;
                            valid_o <= 1'b0;
                            last_o  <= 1'b0;
                            done_o  <= 1'b1;
                        end else begin
                            // Next lanes loaded on the accepting edge, so beats
                            // run back to back while ready_i stays high.
                            base_id_o <= w_next_base;
                            grad_o    <= snap_q[int'(w_next_base)*PREC +: C_BEAT_W];
                            last_o    <= w_next_last;
                        end
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                    done_o  <= 1'b0;
                    if (forward) begin
                        base_id_o <= '0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    valid_o <= 1'b0;
                    last_o  <= 1'b0;
                    done_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
